// File: rtl/window_conv_pipe.sv
// K x K window correlation engine: three-stage products / row sums / total pipeline,
// global valid/ready stall, and a double-buffered (shadow/active) coefficient bank.
module window_conv_pipe #(
  parameter int  WIN_HW        = 3,
  parameter int  DATA_W        = 8,
  parameter int  KERN_W        = 8,
  parameter bit  SIGNED_KERNEL = 1'b1,
  parameter int  SHIFT         = 0,
  localparam int N             = WIN_HW * WIN_HW,
  localparam int AW            = $clog2(N),
  localparam int SUM_W         = DATA_W + KERN_W + $clog2(N),
  localparam int OUT_W         = SUM_W - SHIFT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*DATA_W-1:0]  window,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_data,
  input  logic                 k_wr_en,
  input  logic [AW-1:0]        k_wr_addr,
  input  logic [KERN_W-1:0]    k_wr_data,
  input  logic                 k_commit
);

  localparam int P_W = DATA_W + KERN_W;

  logic [KERN_W-1:0] shadow_reg [N];
  logic [KERN_W-1:0] active_reg [N];

  logic [P_W-1:0]   prod_next [N];
  logic [P_W-1:0]   prod_reg  [N];
  logic [SUM_W-1:0] prod_ext  [N];
  logic [SUM_W-1:0] row_next  [WIN_HW];
  logic [SUM_W-1:0] row_reg   [WIN_HW];
  logic [SUM_W-1:0] total_next;

  logic             v1_reg;
  logic             v2_reg;
  logic             out_valid_reg;
  logic [OUT_W-1:0] out_data_reg;
  logic             advance;

  assign advance   = !out_valid_reg || out_ready;
  assign in_ready  = advance;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

  // Per-tap multipliers; pixels are always zero-extended.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_tap
      logic [DATA_W-1:0] pix;
      assign pix = window[gi*DATA_W +: DATA_W];

      if (SIGNED_KERNEL) begin : g_signed
        logic signed [P_W:0] pix_s;
        logic signed [P_W:0] coef_s;
        logic signed [P_W:0] full_s;
        assign pix_s  = $signed({{(KERN_W+1){1'b0}}, pix});
        assign coef_s = $signed({{(DATA_W+1){active_reg[gi][KERN_W-1]}}, active_reg[gi]});
        assign full_s = pix_s * coef_s;
        assign prod_next[gi] = full_s[P_W-1:0];
        assign prod_ext[gi]  = {{(SUM_W-P_W){prod_reg[gi][P_W-1]}}, prod_reg[gi]};
      end else begin : g_unsigned
        logic [P_W-1:0] pix_u;
        logic [P_W-1:0] coef_u;
        assign pix_u  = {{KERN_W{1'b0}}, pix};
        assign coef_u = {{DATA_W{1'b0}}, active_reg[gi]};
        assign prod_next[gi] = pix_u * coef_u;
        assign prod_ext[gi]  = {{(SUM_W-P_W){1'b0}}, prod_reg[gi]};
      end
    end

    for (gi = 0; gi < WIN_HW; gi++) begin : g_row
      always_comb begin
        row_next[gi] = '0;
        for (int c = 0; c < WIN_HW; c++) begin
          row_next[gi] = row_next[gi] + prod_ext[gi*WIN_HW + c];
        end
      end
    end
  endgenerate

  always_comb begin
    total_next = '0;
    for (int r = 0; r < WIN_HW; r++) begin
      total_next = total_next + row_reg[r];
    end
  end

  // Commit reads shadow_reg before this edge's write, so a same-cycle write lands in shadow only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        shadow_reg[i] <= '0;
        active_reg[i] <= '0;
      end
    end else begin
      if (k_wr_en && (int'(k_wr_addr) < N)) begin
        shadow_reg[k_wr_addr] <= k_wr_data;
      end
      if (k_commit) begin
        for (int i = 0; i < N; i++) begin
          active_reg[i] <= shadow_reg[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_reg        <= 1'b0;
      v2_reg        <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      for (int i = 0; i < N; i++) begin
        prod_reg[i] <= '0;
      end
      for (int r = 0; r < WIN_HW; r++) begin
        row_reg[r] <= '0;
      end
    end else if (advance) begin
      v1_reg        <= in_valid;
      v2_reg        <= v1_reg;
      out_valid_reg <= v2_reg;
      for (int i = 0; i < N; i++) begin
        prod_reg[i] <= prod_next[i];
      end
      for (int r = 0; r < WIN_HW; r++) begin
        row_reg[r] <= row_next[r];
      end
      // Arithmetic and logical shifts differ only in bits that OUT_W truncates away.
      out_data_reg  <= total_next[SUM_W-1 -: OUT_W];
    end
  end

endmodule

// File: tb/tb_window_conv_pipe.sv
// Directed bench for window_conv_pipe: a signed SHIFT=0 instance and an unsigned SHIFT=4 instance.
module tb_window_conv_pipe;

  logic        clk;
  logic        rst_n;

  logic        in_valid;
  logic        in_ready;
  logic [71:0] window;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out_data;
  logic        k_wr_en;
  logic [3:0]  k_wr_addr;
  logic [7:0]  k_wr_data;
  logic        k_commit;

  logic        u_in_valid;
  logic        u_in_ready;
  logic [71:0] u_window;
  logic        u_out_valid;
  logic        u_out_ready;
  logic [15:0] u_out_data;
  logic        u_k_wr_en;
  logic [3:0]  u_k_wr_addr;
  logic [7:0]  u_k_wr_data;
  logic        u_k_commit;

  int errors = 0;
  int checks = 0;

  window_conv_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .window    (window),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .k_wr_en   (k_wr_en),
    .k_wr_addr (k_wr_addr),
    .k_wr_data (k_wr_data),
    .k_commit  (k_commit)
  );

  window_conv_pipe #(.SIGNED_KERNEL(1'b0), .SHIFT(4)) dut_u (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (u_in_valid),
    .in_ready  (u_in_ready),
    .window    (u_window),
    .out_valid (u_out_valid),
    .out_ready (u_out_ready),
    .out_data  (u_out_data),
    .k_wr_en   (u_k_wr_en),
    .k_wr_addr (u_k_wr_addr),
    .k_wr_data (u_k_wr_data),
    .k_commit  (u_k_commit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic logic [71:0] fill(input logic [7:0] v);
    logic [71:0] w;
    for (int i = 0; i < 9; i++) w[i*8 +: 8] = v;
    return w;
  endfunction

  function automatic logic [71:0] col_win(input int c, input logic [7:0] v);
    logic [71:0] w;
    w = '0;
    for (int r = 0; r < 3; r++) w[(r*3 + c)*8 +: 8] = v;
    return w;
  endfunction

  task automatic load_kernel(input logic [71:0] k, input logic commit);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      k_wr_en   = 1'b1;
      k_wr_addr = 4'(i);
      k_wr_data = k[i*8 +: 8];
    end
    @(negedge clk);
    k_wr_en  = 1'b0;
    k_commit = commit;
    @(negedge clk);
    k_commit = 1'b0;
  endtask

  // One window into an empty pipeline; result must show up after exactly three edges.
  task automatic run_window(input string tag, input logic [71:0] w, input logic [19:0] exp);
    @(negedge clk);
    window    = w;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_early"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check(tag, 32'(out_data), 32'(exp));
    $display("window %s -> %0d", tag, $signed(out_data));
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; window = '0; out_ready = 1'b1;
    k_wr_en = 1'b0; k_wr_addr = '0; k_wr_data = '0; k_commit = 1'b0;
    u_in_valid = 1'b0; u_window = '0; u_out_ready = 1'b1;
    u_k_wr_en = 1'b0; u_k_wr_addr = '0; u_k_wr_data = '0; u_k_commit = 1'b0;

    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_data", 32'(out_data), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Cleared kernel gives zero
    run_window("zero_kernel", fill(8'd255), 20'd0);

    // All-ones kernel
    load_kernel(fill(8'd1), 1'b1);
    run_window("ones_255", fill(8'd255), 20'd2295);

    // Sobel-x
    load_kernel({8'h01, 8'h00, 8'hFF, 8'h02, 8'h00, 8'hFE, 8'h01, 8'h00, 8'hFF}, 1'b1);
    run_window("sobel_col2", col_win(2, 8'd255), 20'd1020);
    run_window("sobel_col0", col_win(0, 8'd255), 20'hFFC04);

    // Backpressure: tap0 kernel = 1, windows tap0 = 1..10, out_ready low in cycles 4..8
    load_kernel(72'h01, 1'b1);
    begin
      int sent;
      int got;
      sent = 0;
      got  = 0;
      for (int c = 0; c < 30; c++) begin
        @(negedge clk);
        out_ready = !(c >= 4 && c <= 8);
        in_valid  = (sent < 10);
        window    = 72'(sent + 1);
        #1;
        check("bp_in_ready", 32'(in_ready), 32'(!(c >= 4 && c <= 8)));
        if (c >= 4 && c <= 8) begin
          check("bp_hold_valid", 32'(out_valid), 32'd1);
          check("bp_hold_data", 32'(out_data), 32'd2);
        end
        if (out_valid && out_ready) begin
          check("bp_order", 32'(out_data), 32'(got + 1));
          $display("bp consume %0d", out_data);
          got++;
        end
        if (in_valid && in_ready) sent++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("bp_count", 32'(got), 32'd10);
    end

    // Kernel swap with commit in A's accept cycle
    load_kernel(fill(8'd1), 1'b1);
    load_kernel(fill(8'd2), 1'b0);
    @(negedge clk);
    window = fill(8'd10); in_valid = 1'b1; k_commit = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    k_commit = 1'b0; window = fill(8'd10);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("swap_a_valid", 32'(out_valid), 32'd1);
    check("swap_a", 32'(out_data), 32'd90);
    $display("window swap_a -> %0d", out_data);
    @(negedge clk);
    check("swap_b_valid", 32'(out_valid), 32'd1);
    check("swap_b", 32'(out_data), 32'd180);
    $display("window swap_b -> %0d", out_data);
    @(negedge clk);
    check("swap_drain", 32'(out_valid), 32'd0);

    // Out-of-range addresses are ignored
    for (int a = 9; a < 16; a++) begin
      @(negedge clk);
      k_wr_en = 1'b1; k_wr_addr = 4'(a); k_wr_data = 8'h55;
    end
    @(negedge clk);
    k_wr_en = 1'b0; k_commit = 1'b1;
    @(negedge clk);
    k_commit = 1'b0;
    run_window("bad_addr", fill(8'd10), 20'd180);

    // Same-cycle write and commit: active gets old shadow, shadow gets new value
    @(negedge clk);
    k_wr_en = 1'b1; k_wr_addr = 4'd0; k_wr_data = 8'd5; k_commit = 1'b1;
    @(negedge clk);
    k_wr_en = 1'b0; k_commit = 1'b0;
    run_window("wr_commit_old", fill(8'd10), 20'd180);
    @(negedge clk);
    k_commit = 1'b1;
    @(negedge clk);
    k_commit = 1'b0;
    run_window("wr_commit_new", fill(8'd10), 20'd210);

    // Unsigned instance with SHIFT = 4
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      u_k_wr_en = 1'b1; u_k_wr_addr = 4'(i); u_k_wr_data = 8'd255;
    end
    @(negedge clk);
    u_k_wr_en = 1'b0; u_k_commit = 1'b1;
    @(negedge clk);
    u_k_commit = 1'b0; u_window = fill(8'd255); u_in_valid = 1'b1; u_out_ready = 1'b1;
    @(negedge clk);
    u_in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("u_shift_valid", 32'(u_out_valid), 32'd1);
    check("u_shift_data", 32'(u_out_data), 32'd36576);
    $display("window u_shift -> %0d", u_out_data);

    // Reset mid-stream with three results in flight
    load_kernel(fill(8'd1), 1'b1);
    @(negedge clk);
    window = fill(8'd1); in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    check("pre_rst_full", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      check("post_rst_no_output", 32'(seen), 32'd0);
    end
    run_window("post_rst_kernel", fill(8'd200), 20'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
